// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared FSM encodings and divide length for the MDU
package mdu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - decode-stage request and HI/LO result bundle for the MDU
interface mdu_if;

    logic        mult;
    logic        div;
    logic        mdsign;
    logic [1:0]  mt_wen;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output mult, div, mdsign, mt_wen, src_a, src_b, cancel,
        input  stall, done, hi, lo
    );

    modport slave (
        input  mult, div, mdsign, mt_wen, src_a, src_b, cancel,
        output stall, done, hi, lo
    );

endinterface

// File: rtl/mdu_div.sv
// rtl/mdu_div.sv - iterative restoring divider, one quotient bit per cycle
module mdu_div
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        cancel_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      den_q, den_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted, diff;
    logic [31:0] rem_step, quo_step;
    logic        last;

    // One restoring step plus the final sign fix; the last step's result is
    // presented combinationally so the top can commit it on the same edge.
    always_comb begin
        a_neg   = signed_i & a_i[31];
        b_neg   = signed_i & b_i[31];
        a_mag   = a_neg ? (~a_i + 32'd1) : a_i;
        b_mag   = b_neg ? (~b_i + 32'd1) : b_i;
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, den_q};
        if (diff[32]) begin
            rem_step = shifted[31:0];
            quo_step = {quo_q[30:0], 1'b0};
        end else begin
            rem_step = diff[31:0];
            quo_step = {quo_q[30:0], 1'b1};
        end
        last   = run_q & (cnt_q == CNT_W'(DIV_CYCLES - 1));
        done_o = last;
        quo_o  = qneg_q ? (~quo_step + 32'd1) : quo_step;
        rem_o  = rneg_q ? (~rem_step + 32'd1) : rem_step;

        run_d  = run_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (cancel_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = a_mag;
            den_d  = b_mag;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
        end else if (run_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multiply/divide unit with HI/LO registers and issue stall
module mdu
    import mdu_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    mdu_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_q, sign_d;

    logic               req, accept, div_start, div_done;
    logic [31:0]        div_quo, div_rem;
    logic signed [63:0] mul_a, mul_b, product;

    assign req       = bus.mult | bus.div;
    assign accept    = (state_q == ST_IDLE) & req & ~bus.cancel;
    assign div_start = accept & bus.div;

    assign bus.stall = resetn & (accept | (state_q == ST_MUL) | (state_q == ST_DIV));
    assign bus.done  = resetn & (state_q == ST_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    mdu_div u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (div_start),
        .cancel_i (bus.cancel),
        .signed_i (bus.mdsign),
        .a_i      (bus.src_a),
        .b_i      (bus.src_b),
        .done_o   (div_done),
        .quo_o    (div_quo),
        .rem_o    (div_rem)
    );

    // Next state, operand latch and HI/LO update; cancel beats every write.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        mul_a   = {{32{sign_q & a_q[31]}}, a_q};
        mul_b   = {{32{sign_q & b_q[31]}}, b_q};
        product = mul_a * mul_b;
        case (state_q)
            ST_IDLE: begin
                if (!bus.cancel) begin
                    if (req) begin
                        a_d     = bus.src_a;
                        b_d     = bus.src_b;
                        sign_d  = bus.mdsign;
                        state_d = bus.div ? ST_DIV : ST_MUL;
                    end else begin
                        if (bus.mt_wen[1]) hi_d = bus.src_a;
                        if (bus.mt_wen[0]) lo_d = bus.src_a;
                    end
                end
            end
            ST_MUL: begin
                if (bus.cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (bus.cancel) begin
                    state_d = ST_IDLE;
                end else if (div_done) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
        end
    end

endmodule
